scheduler: RTL and testbench
============================

# scheduler

Single-issue reservation-station scheduler for one functional-unit (FU) cluster, placed between dispatch and register read. It accepts dispatched micro-ops into a free RS entry and tracks each entry's producer dependencies in a dependency-matrix row. It clears those dependencies as the global ready mask broadcasts completions, selects one ready entry per cycle, and fires that entry's payload to register read. Entries stay allocated after firing until the execute stage frees them.

## Interface
Parameters (from `CORE_PKG`, not module parameters):
- `RS_ENTRIES`, 8: number of RS entries.
- `NUM_FUS`, 4: number of FU schedulers; dependency space is `RS_ENTRIES*NUM_FUS` bits (D).
- `NUM_PREGS`, 128: physical registers; preg width P = `$clog2(NUM_PREGS)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `local_ready_mask`  out  RS_ENTRIES  one-hot of the entry fired this cycle; this scheduler's slice of the global mask.
- `global_ready_mask`  in  D  per-producer "result ready" bits from all schedulers.
- `disp_if.disp_valid`  in  1  dispatch request.
- `disp_if.disp_pkt`  in  `disp_packet_t`  payload: dst/src1/src2 preg, `imm_val`[32], `pc`[32], `instr_valid`.
- `disp_if.dependency_mask`  in  D  producers this micro-op waits on.
- `disp_if.rs_entry_idx`  out  log2(RS_ENTRIES)  lowest free entry, which is where the next dispatch lands.
- `disp_if.rs_full`  out  1  all entries valid.
- `exec_if.fu_ready`  in  1  FU can accept an issue this cycle.
- `exec_if.free_valid` / `exec_if.free_idx`  in  1 / log2(RS_ENTRIES)  deallocate an entry.
- `reg_read_if.fire_valid`  out  1  issue valid.
- `reg_read_if.sched_pkt`  out  `disp_packet_t`  payload of the fired entry.

## Operation
- Per-entry state: `entry_valid`, `issued`, dependency row[D], payload RAM word.
- **Dispatch.** On `disp_valid && !rs_full` at a rising edge, the entry at `rs_entry_idx` gets:
  - `valid=1`, `issued=0`
  - row = `dependency_mask` (see Configuration)
  - payload = `disp_pkt`.
- **Dispatch while full.** Dispatch with `rs_full=1` is dropped silently; no state changes.
- **Wakeup.** Each cycle, every row clears the bits set in `global_ready_mask`. Clears are sticky: a later deassertion of a mask bit does not re-set it.
- **Request.** An entry requests when `valid && row==0 && !issued`.
- **Select.** Fixed priority, lowest index first. A grant occurs only when some entry requests and `fu_ready=1`. At the grant edge the entry's `issued` bit sets.
- **Free.** `free_valid` clears `valid` and `issued` of `free_idx`.
  - A free and a dispatch in the same cycle are both honoured. `rs_entry_idx` and `rs_full` reflect the pre-edge state.
  - Freeing an invalid entry has no effect.
- `rs_full` and `rs_entry_idx` are combinational from `entry_valid`. `rs_entry_idx` is 0 when full.

## Timing
- Dispatch at edge N: entry valid after N.
  - With a zero dependency row, it requests during cycle N+1 and is granted at edge N+1.
  - `fire_valid`, `sched_pkt` and `local_ready_mask` are registered and visible after edge N+1, for one cycle per grant.
- A dependency cleared at edge M gives a request after edge M. If no older entry is requesting, grant occurs at edge M+1.
- Throughput: at most one fire per cycle.
- Reset values: all `valid`/`issued`/rows 0, `fire_valid=0`, `sched_pkt=0`, `local_ready_mask=0`, `rs_full=0`, `rs_entry_idx=0`. Payload RAM is not reset.
- Reset asserted mid-operation discards all entries and any in-flight fire.

## Configuration
- `SCHED_DISPATCH_WAKEUP_EN` defined: the stored row is `dependency_mask & ~global_ready_mask`, so producers completing in the dispatch cycle are not missed.
- Not defined: the row is stored as `dependency_mask` unmodified, and the first clear happens on the following edge.

## Structure
- `CORE_PKG` holds:
  - `RS_ENTRIES`, `NUM_FUS`, `NUM_PREGS`
  - `disp_packet_t`
- Interfaces `dispatch_scheduler_if`, `execute_scheduler_if` and `scheduler_reg_read_if` live in shared interface files.
- One sub-module, `wakeup`, holds the valid bits and dependency matrix and produces the request vector. The select logic, payload RAM and output register stay in `scheduler`.

## Test plan
- Reset, then dispatch mask 0, dst 10, src 20/30, pc 0x1000 with `fu_ready=1`:
  - entry 0 valid
  - payload dst 10
  - next cycle `fire_valid=1`, `sched_pkt` = {10, 20, 30, 0x1000}, `local_ready_mask=...0001`
  - entry 0 then stops requesting.
- Dispatch with mask `...11`, dst 15, pc 0x2000:
  - no request
  - set global bit0 → row `...10`
  - set bits 1:0 → row 0 and request
  - drop mask to 0 → row stays 0.
- Reset, dispatch `RS_ENTRIES` no-dependency entries (dst i, pc 0x4000+16i) without freeing: all valid, `rs_full=1`.
- While full, dispatch dst 99: valid count unchanged, `rs_full` stays 1. Then assert `free_idx=3` → `rs_entry_idx=3`, `rs_full=0`.
- Reset, dispatch three entries (dst 6/16/26, pc 0xA000/0xB000/0xC000, imm 0x11/0x22/0x33): RAM entries 0–2 hold exactly these values.
- Two entries ready with `fu_ready=0`: no fire. Raise `fu_ready`: entry 0 fires first, entry 1 on the next cycle.

Source files
------------

// File: rtl/scheduler_pkg.sv
// Shared sizing, payload type and priority helper for the RS scheduler.
// Optional dispatch-cycle wakeup is selected by SCHED_DISPATCH_WAKEUP_EN (see scheduler.sv).
package scheduler_pkg;

   localparam int unsigned RS_ENTRIES = 8;
   localparam int unsigned NUM_FUS    = 4;
   localparam int unsigned NUM_PREGS  = 128;

   localparam int unsigned DEP_W  = RS_ENTRIES * NUM_FUS;
   localparam int unsigned PREG_W = $clog2(NUM_PREGS);
   localparam int unsigned IDX_W  = $clog2(RS_ENTRIES);

   typedef logic [IDX_W-1:0]      rs_idx_t;
   typedef logic [RS_ENTRIES-1:0] rs_vec_t;
   typedef logic [DEP_W-1:0]      dep_mask_t;

   typedef struct packed {
      logic [PREG_W-1:0] dst_preg;
      logic [PREG_W-1:0] src1_preg;
      logic [PREG_W-1:0] src2_preg;
      logic [31:0]       imm_val;
      logic [31:0]       pc;
      logic              instr_valid;
   } disp_packet_t;

   // Index of the lowest set bit; 0 when no bit is set.
   function automatic rs_idx_t lowest_set(rs_vec_t v);
      lowest_set = '0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
         if (v[i]) lowest_set = rs_idx_t'(i);
      end
   endfunction

endpackage

// File: rtl/scheduler_if.sv
// Dispatch, execute and register-read handshakes of the RS scheduler.
// The scheduler always takes the slave side of dispatch/execute and the master side of reg read.
interface dispatch_scheduler_if;
   import scheduler_pkg::*;

   logic         disp_valid;
   disp_packet_t disp_pkt;
   dep_mask_t    dependency_mask;
   rs_idx_t      rs_entry_idx;
   logic         rs_full;

   modport master (output disp_valid, disp_pkt, dependency_mask, input rs_entry_idx, rs_full);
   modport slave  (input disp_valid, disp_pkt, dependency_mask, output rs_entry_idx, rs_full);
endinterface

interface execute_scheduler_if;
   import scheduler_pkg::*;

   logic    fu_ready;
   logic    free_valid;
   rs_idx_t free_idx;

   modport master (output fu_ready, free_valid, free_idx);
   modport slave  (input fu_ready, free_valid, free_idx);
endinterface

interface scheduler_reg_read_if;
   import scheduler_pkg::*;

   logic         fire_valid;
   disp_packet_t sched_pkt;

   modport master (output fire_valid, sched_pkt);
   modport slave  (input fire_valid, sched_pkt);
endinterface

// File: rtl/scheduler_wakeup.sv
// Wakeup block: entry valid/issued bits and the dependency matrix, producing per-entry requests.
module scheduler_wakeup
   import scheduler_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      disp_en,
   input  rs_idx_t   disp_idx,
   input  dep_mask_t disp_row,
   input  dep_mask_t global_ready_mask,
   input  rs_vec_t   grant,
   input  logic      free_valid,
   input  rs_idx_t   free_idx,
   output rs_vec_t   entry_valid,
   output rs_vec_t   request
);

   rs_vec_t   valid_q, valid_d;
   rs_vec_t   issued_q, issued_d;
   dep_mask_t row_q [RS_ENTRIES];
   dep_mask_t row_d [RS_ENTRIES];

   always_comb begin
      valid_d  = valid_q;
      issued_d = issued_q | grant;
      for (int i = 0; i < RS_ENTRIES; i++) begin
         row_d[i] = row_q[i] & ~global_ready_mask;
      end
      // Free precedes dispatch; a dispatch always targets an invalid entry, so the two never collide.
      if (free_valid && valid_q[free_idx]) begin
         valid_d[free_idx]  = 1'b0;
         issued_d[free_idx] = 1'b0;
      end
      if (disp_en) begin
         valid_d[disp_idx]  = 1'b1;
         issued_d[disp_idx] = 1'b0;
         row_d[disp_idx]    = disp_row;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= '0;
         issued_q <= '0;
         for (int i = 0; i < RS_ENTRIES; i++) row_q[i] <= '0;
      end else begin
         valid_q  <= valid_d;
         issued_q <= issued_d;
         for (int i = 0; i < RS_ENTRIES; i++) row_q[i] <= row_d[i];
      end
   end

   always_comb begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
         request[i] = valid_q[i] & ~issued_q[i] & (row_q[i] == '0);
      end
   end

   assign entry_valid = valid_q;

endmodule

// File: rtl/scheduler.sv
// Single-issue RS scheduler: allocate, wake up, select lowest ready entry, fire payload.
// Define SCHED_DISPATCH_WAKEUP_EN to filter the stored row by completions in the dispatch cycle.
module scheduler
   import scheduler_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   output rs_vec_t              local_ready_mask,
   input  dep_mask_t            global_ready_mask,
   dispatch_scheduler_if.slave  disp_if,
   execute_scheduler_if.slave   exec_if,
   scheduler_reg_read_if.master reg_read_if
);

   rs_vec_t      entry_valid;
   rs_vec_t      request;
   rs_vec_t      grant;
   rs_idx_t      grant_idx;
   rs_idx_t      alloc_idx;
   logic         full;
   logic         disp_en;
   logic         any_grant;
   dep_mask_t    disp_row;
   disp_packet_t payload_q [RS_ENTRIES];

   logic         fire_valid_q;
   disp_packet_t sched_pkt_q;
   rs_vec_t      local_ready_mask_q;

   assign full      = &entry_valid;
   assign alloc_idx = full ? '0 : lowest_set(~entry_valid);
   assign disp_en   = disp_if.disp_valid & ~full;

`ifdef SCHED_DISPATCH_WAKEUP_EN
   assign disp_row = disp_if.dependency_mask & ~global_ready_mask;
`else
   assign disp_row = disp_if.dependency_mask;
`endif

   assign grant_idx = lowest_set(request);
   assign any_grant = (|request) & exec_if.fu_ready;
   assign grant     = any_grant ? (rs_vec_t'(1) << grant_idx) : '0;

   scheduler_wakeup u_wakeup (
      .clk               (clk),
      .rst               (rst),
      .disp_en           (disp_en),
      .disp_idx          (alloc_idx),
      .disp_row          (disp_row),
      .global_ready_mask (global_ready_mask),
      .grant             (grant),
      .free_valid        (exec_if.free_valid),
      .free_idx          (exec_if.free_idx),
      .entry_valid       (entry_valid),
      .request           (request)
   );

   // Payload RAM carries no reset; entries are only read once written by dispatch.
   always_ff @(posedge clk) begin
      if (disp_en) payload_q[alloc_idx] <= disp_if.disp_pkt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fire_valid_q       <= 1'b0;
         sched_pkt_q        <= '0;
         local_ready_mask_q <= '0;
      end else begin
         fire_valid_q       <= any_grant;
         local_ready_mask_q <= grant;
         if (any_grant) sched_pkt_q <= payload_q[grant_idx];
      end
   end

   assign disp_if.rs_full      = full;
   assign disp_if.rs_entry_idx = alloc_idx;
   assign reg_read_if.fire_valid = fire_valid_q;
   assign reg_read_if.sched_pkt  = sched_pkt_q;
   assign local_ready_mask       = local_ready_mask_q;

endmodule

// File: tb/tb_scheduler.sv
// Self-checking bench for scheduler: fired payloads are checked against a scoreboard queue.
module tb_scheduler;
   import scheduler_pkg::*;

   logic      clk = 1'b0;
   logic      rst;
   rs_vec_t   local_ready_mask;
   dep_mask_t global_ready_mask;

   dispatch_scheduler_if disp_if ();
   execute_scheduler_if  exec_if ();
   scheduler_reg_read_if reg_read_if ();

   scheduler dut (
      .clk               (clk),
      .rst               (rst),
      .local_ready_mask  (local_ready_mask),
      .global_ready_mask (global_ready_mask),
      .disp_if           (disp_if),
      .exec_if           (exec_if),
      .reg_read_if       (reg_read_if)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   disp_packet_t exp_q[$];

   function automatic disp_packet_t mk_pkt(int dst, int s1, int s2, int imm, int pc);
      disp_packet_t p;
      p.dst_preg    = PREG_W'(dst);
      p.src1_preg   = PREG_W'(s1);
      p.src2_preg   = PREG_W'(s2);
      p.imm_val     = 32'(imm);
      p.pc          = 32'(pc);
      p.instr_valid = 1'b1;
      return p;
   endfunction

   // Scoreboard: every fire must match the oldest outstanding expectation.
   always @(negedge clk) begin : monitor
      disp_packet_t exp_pkt;
      if (!rst && reg_read_if.fire_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL fire_unexpected: got pkt %h, expected no fire", reg_read_if.sched_pkt);
         end else begin
            exp_pkt = exp_q.pop_front();
            if (reg_read_if.sched_pkt !== exp_pkt) begin
               n_err++;
               $display("FAIL fire_pkt: got %h, expected %h", reg_read_if.sched_pkt, exp_pkt);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      disp_if.disp_valid      = 1'b0;
      disp_if.disp_pkt        = '0;
      disp_if.dependency_mask = '0;
      exec_if.fu_ready        = 1'b0;
      exec_if.free_valid      = 1'b0;
      exec_if.free_idx        = '0;
      global_ready_mask       = '0;
   endtask

   task automatic do_reset;
      idle_inputs();
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0 || local_ready_mask !== '0) begin
         n_err++;
         $display("FAIL reset_fire: fire=%b mask=%b, expected 0/0",
                  reg_read_if.fire_valid, local_ready_mask);
      end
      n_cmp++;
      if (reg_read_if.sched_pkt !== '0) begin
         n_err++;
         $display("FAIL reset_pkt: got %h, expected 0", reg_read_if.sched_pkt);
      end
      n_cmp++;
      if (disp_if.rs_full !== 1'b0 || disp_if.rs_entry_idx !== '0 || dut.u_wakeup.valid_q !== '0)
      begin
         n_err++;
         $display("FAIL reset_state: full=%b idx=%0d valid=%b, expected 0/0/0",
                  disp_if.rs_full, disp_if.rs_entry_idx, dut.u_wakeup.valid_q);
      end
   endtask

   task automatic test_single_issue;
      exec_if.fu_ready        = 1'b1;
      disp_if.disp_valid      = 1'b1;
      disp_if.disp_pkt        = mk_pkt(10, 20, 30, 0, 'h1000);
      disp_if.dependency_mask = '0;
      exp_q.push_back(mk_pkt(10, 20, 30, 0, 'h1000));
      tick();
      disp_if.disp_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.valid_q !== 8'h01 || dut.payload_q[0].dst_preg !== 7'd10) begin
         n_err++;
         $display("FAIL single_alloc: valid=%b dst=%0d, expected 00000001/10",
                  dut.u_wakeup.valid_q, dut.payload_q[0].dst_preg);
      end
      n_cmp++;
      if (dut.u_wakeup.request !== 8'h01 || reg_read_if.fire_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_req: req=%b fire=%b, expected 00000001/0",
                  dut.u_wakeup.request, reg_read_if.fire_valid);
      end
      tick();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b1 || local_ready_mask !== 8'h01) begin
         n_err++;
         $display("FAIL single_fire: fire=%b mask=%b, expected 1/00000001",
                  reg_read_if.fire_valid, local_ready_mask);
      end
      n_cmp++;
      if (dut.u_wakeup.request !== 8'h00) begin
         n_err++;
         $display("FAIL single_issued: req=%b, expected 00000000", dut.u_wakeup.request);
      end
      tick();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_oneshot: fire=%b, expected 0", reg_read_if.fire_valid);
      end
   endtask

   task automatic test_wakeup;
      n_cmp++;
      if (disp_if.rs_entry_idx !== 3'd1) begin
         n_err++;
         $display("FAIL wake_idx: got %0d, expected 1", disp_if.rs_entry_idx);
      end
      disp_if.disp_valid      = 1'b1;
      disp_if.disp_pkt        = mk_pkt(15, 0, 0, 0, 'h2000);
      disp_if.dependency_mask = 32'h3;
      tick();
      disp_if.disp_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.row_q[1] !== 32'h3 || dut.u_wakeup.request !== 8'h00) begin
         n_err++;
         $display("FAIL wake_dep: row=%h req=%b, expected 3/00000000",
                  dut.u_wakeup.row_q[1], dut.u_wakeup.request);
      end
      global_ready_mask = 32'h1;
      tick();
      n_cmp++;
      if (dut.u_wakeup.row_q[1] !== 32'h2 || dut.u_wakeup.request !== 8'h00) begin
         n_err++;
         $display("FAIL wake_partial: row=%h req=%b, expected 2/00000000",
                  dut.u_wakeup.row_q[1], dut.u_wakeup.request);
      end
      global_ready_mask = 32'h3;
      exp_q.push_back(mk_pkt(15, 0, 0, 0, 'h2000));
      tick();
      n_cmp++;
      if (dut.u_wakeup.row_q[1] !== 32'h0 || dut.u_wakeup.request !== 8'h02) begin
         n_err++;
         $display("FAIL wake_clear: row=%h req=%b, expected 0/00000010",
                  dut.u_wakeup.row_q[1], dut.u_wakeup.request);
      end
      global_ready_mask = 32'h0;
      tick();
      n_cmp++;
      if (dut.u_wakeup.row_q[1] !== 32'h0) begin
         n_err++;
         $display("FAIL wake_sticky: row=%h, expected 0", dut.u_wakeup.row_q[1]);
      end
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b1 || local_ready_mask !== 8'h02) begin
         n_err++;
         $display("FAIL wake_fire: fire=%b mask=%b, expected 1/00000010",
                  reg_read_if.fire_valid, local_ready_mask);
      end
      tick();
   endtask

   task automatic test_full;
      do_reset();
      for (int i = 0; i < RS_ENTRIES; i++) begin
         n_cmp++;
         if (disp_if.rs_entry_idx !== rs_idx_t'(i)) begin
            n_err++;
            $display("FAIL full_alloc_idx: got %0d, expected %0d", disp_if.rs_entry_idx, i);
         end
         disp_if.disp_valid = 1'b1;
         disp_if.disp_pkt   = mk_pkt(i, 0, 0, 0, 'h4000 + 16 * i);
         tick();
      end
      disp_if.disp_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.valid_q !== 8'hFF || disp_if.rs_full !== 1'b1 ||
          disp_if.rs_entry_idx !== 3'd0) begin
         n_err++;
         $display("FAIL full_state: valid=%b full=%b idx=%0d, expected 11111111/1/0",
                  dut.u_wakeup.valid_q, disp_if.rs_full, disp_if.rs_entry_idx);
      end
      disp_if.disp_valid = 1'b1;
      disp_if.disp_pkt   = mk_pkt(99, 0, 0, 0, 0);
      tick();
      disp_if.disp_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.valid_q !== 8'hFF || disp_if.rs_full !== 1'b1 ||
          dut.payload_q[0].dst_preg !== 7'd0) begin
         n_err++;
         $display("FAIL full_drop: valid=%b full=%b dst0=%0d, expected 11111111/1/0",
                  dut.u_wakeup.valid_q, disp_if.rs_full, dut.payload_q[0].dst_preg);
      end
      exec_if.free_valid = 1'b1;
      exec_if.free_idx   = 3'd3;
      tick();
      exec_if.free_valid = 1'b0;
      n_cmp++;
      if (disp_if.rs_entry_idx !== 3'd3 || disp_if.rs_full !== 1'b0 ||
          dut.u_wakeup.valid_q !== 8'hF7) begin
         n_err++;
         $display("FAIL full_free: idx=%0d full=%b valid=%b, expected 3/0/11110111",
                  disp_if.rs_entry_idx, disp_if.rs_full, dut.u_wakeup.valid_q);
      end
      // Free and dispatch in the same cycle: dispatch lands at the pre-edge free slot.
      disp_if.disp_valid = 1'b1;
      disp_if.disp_pkt   = mk_pkt(42, 0, 0, 0, 0);
      exec_if.free_valid = 1'b1;
      exec_if.free_idx   = 3'd5;
      tick();
      disp_if.disp_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.valid_q !== 8'hDF || dut.payload_q[3].dst_preg !== 7'd42 ||
          disp_if.rs_entry_idx !== 3'd5) begin
         n_err++;
         $display("FAIL free_disp_same: valid=%b dst3=%0d idx=%0d, expected 11011111/42/5",
                  dut.u_wakeup.valid_q, dut.payload_q[3].dst_preg, disp_if.rs_entry_idx);
      end
      tick();
      exec_if.free_valid = 1'b0;
      n_cmp++;
      if (dut.u_wakeup.valid_q !== 8'hDF) begin
         n_err++;
         $display("FAIL free_invalid: valid=%b, expected 11011111", dut.u_wakeup.valid_q);
      end
   endtask

   task automatic test_payload_and_priority;
      int dsts[3] = '{6, 16, 26};
      int pcs[3]  = '{'hA000, 'hB000, 'hC000};
      int imms[3] = '{'h11, 'h22, 'h33};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         disp_if.disp_valid = 1'b1;
         disp_if.disp_pkt   = mk_pkt(dsts[i], 1, 2, imms[i], pcs[i]);
         tick();
      end
      disp_if.disp_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if (dut.payload_q[i] !== mk_pkt(dsts[i], 1, 2, imms[i], pcs[i])) begin
            n_err++;
            $display("FAIL ram_entry%0d: got %h, expected %h", i, dut.payload_q[i],
                     mk_pkt(dsts[i], 1, 2, imms[i], pcs[i]));
         end
      end
      tick();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0 || dut.u_wakeup.request !== 8'h07) begin
         n_err++;
         $display("FAIL prio_stall: fire=%b req=%b, expected 0/00000111",
                  reg_read_if.fire_valid, dut.u_wakeup.request);
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(mk_pkt(dsts[i], 1, 2, imms[i], pcs[i]));
      exec_if.fu_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++;
         if (reg_read_if.fire_valid !== 1'b1 || local_ready_mask !== rs_vec_t'(1 << i)) begin
            n_err++;
            $display("FAIL prio_order%0d: fire=%b mask=%b, expected 1/%b", i,
                     reg_read_if.fire_valid, local_ready_mask, rs_vec_t'(1 << i));
         end
      end
      tick();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0) begin
         n_err++;
         $display("FAIL prio_drain: fire=%b, expected 0", reg_read_if.fire_valid);
      end
   endtask

   task automatic test_reset_midop;
      do_reset();
      exec_if.fu_ready   = 1'b1;
      disp_if.disp_valid = 1'b1;
      disp_if.disp_pkt   = mk_pkt(7, 0, 0, 0, 'h5000);
      tick();
      disp_if.disp_valid = 1'b0;
      tick();
      // Fire is in flight now; asynchronous reset must drop it before the monitor samples.
      rst = 1'b1;
      #1;
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0 || local_ready_mask !== '0 ||
          dut.u_wakeup.valid_q !== '0) begin
         n_err++;
         $display("FAIL reset_midop: fire=%b mask=%b valid=%b, expected 0/0/0",
                  reg_read_if.fire_valid, local_ready_mask, dut.u_wakeup.valid_q);
      end
      exp_q.delete();
      tick();
      rst = 1'b0;
      repeat (2) tick();
      n_cmp++;
      if (reg_read_if.fire_valid !== 1'b0) begin
         n_err++;
         $display("FAIL reset_discard: fire=%b, expected 0", reg_read_if.fire_valid);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick();
      test_reset();
      test_single_issue();
      test_wakeup();
      test_full();
      test_payload_and_priority();
      test_reset_midop();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_left: %0d outstanding, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
